// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake bundle: head-of-queue {pc, instr} with valid/ready.
// master = fetch side (drives valid/pc/instr), slave = decode side (drives ready).
interface instr_fetch_unit_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses combinational imem, queues {pc, instr} to decode.
// Ports: clk, rst (async high), imem_addr/imem_instr, redirect_valid/redirect_pc, halt, out_if (master).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_instr,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      halt,
    instr_fetch_unit_if.master        out_if
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic pop;
    logic push;
    logic can_push;

    // Low target bits are discarded; this keeps them visibly consumed.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr        = fetch_pc_q;
    assign out_if.out_valid = (count_q != '0);
    assign out_if.out_pc    = pc_mem_q[rd_ptr_q];
    assign out_if.out_instr = instr_mem_q[rd_ptr_q];

    // A full queue can still accept when the head leaves in the same cycle.
    assign pop      = out_if.out_valid & out_if.out_ready & ~redirect_valid;
    assign can_push = (count_q < CW'(DEPTH)) | pop;
    assign push     = can_push & ~halt & ~redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset, then random vs queue model.
// Instruction memory is a hash of the address, driven combinationally.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    instr_fetch_unit_if dif ();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_if         (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of {pc, instr} and a fetch address.
    logic [63:0] mq[$];
    logic [31:0] mpc;

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
    endtask

    task automatic model_check(input string tag);
        check({tag, " addr"}, imem_addr, mpc);
        check({tag, " valid"}, {31'd0, dif.out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check({tag, " pc"}, dif.out_pc, mq[0][63:32]);
            check({tag, " instr"}, dif.out_instr, mq[0][31:0]);
        end
    endtask

    // Apply inputs for one cycle, advance the model across the edge, sample after it.
    task automatic cycle(input logic rdy, input logic h, input logic rv, input logic [31:0] rp);
        bit pop;
        bit push;
        dif.out_ready  = rdy;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rp;
        pop  = (mq.size() != 0) && rdy && !rv;
        push = ((mq.size() < DEPTH) || pop) && !h && !rv;
        @(posedge clk);
        if (rv) begin
            mq.delete();
            mpc = {rp[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        hlt;
        logic        rv;
        logic [31:0] rp;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic rdy, input logic hlt, input logic rv,
                                input logic [31:0] rp, input logic ev,
                                input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.rdy = rdy; v.hlt = hlt; v.rv = rv; v.rp = rp;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    initial begin
        tests = 0;
        fails = 0;

        // backpressure from reset, release
        tbl[0]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h4);
        tbl[1]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h8);
        tbl[2]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h8);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h8);
        tbl[4]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h8);
        tbl[5]  = mk(1, 0, 0, 0, 1, 32'h4, 32'hC);
        tbl[6]  = mk(1, 0, 0, 0, 1, 32'h8, 32'h10);
        tbl[7]  = mk(1, 0, 0, 0, 1, 32'hC, 32'h14);
        // redirect with misaligned target
        tbl[8]  = mk(1, 0, 1, 32'h43, 0, 32'h0, 32'h40);
        tbl[9]  = mk(1, 0, 0, 0, 1, 32'h40, 32'h44);
        tbl[10] = mk(0, 0, 0, 0, 1, 32'h40, 32'h48);
        // redirect while full, ready high
        tbl[11] = mk(1, 0, 1, 32'h43, 0, 32'h0, 32'h40);
        tbl[12] = mk(1, 0, 0, 0, 1, 32'h40, 32'h44);
        tbl[13] = mk(0, 0, 0, 0, 1, 32'h40, 32'h48);
        // halt: drain, address frozen, then resume
        tbl[14] = mk(1, 1, 0, 0, 1, 32'h44, 32'h48);
        tbl[15] = mk(1, 1, 0, 0, 0, 32'h0, 32'h48);
        tbl[16] = mk(1, 1, 0, 0, 0, 32'h0, 32'h48);
        tbl[17] = mk(1, 0, 0, 0, 1, 32'h48, 32'h4C);
        // wrap of the 32-bit address
        tbl[18] = mk(1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFF8);
        tbl[19] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        tbl[20] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        tbl[21] = mk(1, 0, 0, 0, 1, 32'h0, 32'h4);
        tbl[22] = mk(0, 0, 0, 0, 1, 32'h0, 32'h8);

        rst            = 1'b1;
        dif.out_ready  = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        #1;
        check("reset valid", {31'd0, dif.out_valid}, 32'd0);
        check("reset pc", dif.out_pc, 32'd0);
        check("reset instr", dif.out_instr, 32'd0);
        check("reset addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].rdy, tbl[i].hlt, tbl[i].rv, tbl[i].rp);
            check($sformatf("vec%0d valid", i), {31'd0, dif.out_valid}, {31'd0, tbl[i].ev});
            check($sformatf("vec%0d addr", i), imem_addr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d pc", i), dif.out_pc, tbl[i].epc);
                check($sformatf("vec%0d instr", i), dif.out_instr, mem_word(tbl[i].epc));
            end
            model_check($sformatf("vec%0d model", i));
        end

        // Asynchronous reset between edges with two entries queued.
        check("pre-rst valid", {31'd0, dif.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", {31'd0, dif.out_valid}, 32'd0);
        check("async rst pc", dif.out_pc, 32'd0);
        check("async rst instr", dif.out_instr, 32'd0);
        check("async rst addr", imem_addr, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic r;
            logic h;
            logic rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 9) < 7);
            h  = ($urandom_range(0, 9) < 2);
            rv = ($urandom_range(0, 19) == 0);
            rp = $urandom();
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            cycle(r, h, rv, rp);
            model_check($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
